// File: rtl/dpram_be_clr_if.sv
// Signal bundle for dpram_be_clr: two byte-lane RAM ports plus clear/busy/collision.
interface dpram_be_clr_if #(
  parameter int unsigned adr_width  = 9,
  parameter int unsigned lane_width = 9,
  parameter int unsigned lanes      = 4
) ();
  localparam int unsigned dat_width = lanes * lane_width;

  logic                 clear;
  logic                 busy;
  logic                 collision;
  logic [adr_width-1:0] adr0;
  logic                 we0;
  logic [lanes-1:0]     sel0;
  logic [dat_width-1:0] din0;
  logic [dat_width-1:0] dout0;
  logic [adr_width-1:0] adr1;
  logic                 we1;
  logic [lanes-1:0]     sel1;
  logic [dat_width-1:0] din1;
  logic [dat_width-1:0] dout1;

  modport master (
    output clear, adr0, we0, sel0, din0, adr1, we1, sel1, din1,
    input  busy, collision, dout0, dout1
  );

  modport slave (
    input  clear, adr0, we0, sel0, din0, adr1, we1, sel1, din1,
    output busy, collision, dout0, dout1
  );
endinterface

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with per-lane write enables, selectable read-during-write,
// same-address collision flag and a hardware clear sweep after reset or on request.
module dpram_be_clr #(
  parameter int unsigned adr_width  = 9,
  parameter int unsigned lane_width = 9,
  parameter int unsigned lanes      = 4,
  parameter int unsigned rdw_mode   = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  dpram_be_clr_if.slave   bus
);
  localparam int unsigned dat_width = lanes * lane_width;
  localparam int unsigned depth     = 1 << adr_width;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e               state_q, state_d;
  logic [adr_width-1:0] cnt_q, cnt_d;
  logic [dat_width-1:0] dout0_q, dout0_d;
  logic [dat_width-1:0] dout1_q, dout1_d;
  logic                 collision_q, collision_d;

  logic                 busy;
  logic                 clr_we;
  logic [lanes-1:0]     wr0, wr1;
  logic [dat_width-1:0] rd0_old, rd0_new, rd1_old, rd1_new;

  logic [dat_width-1:0] mem [depth];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      collision_q <= collision_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + adr_width'(1);
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Output / datapath control
  always_comb begin
    busy   = (state_q == ST_CLEAR);
    clr_we = busy;
    wr0    = busy ? '0 : ({lanes{bus.we0}} & bus.sel0);
    wr1    = busy ? '0 : ({lanes{bus.we1}} & bus.sel1);
  end

  // Post-write view of each addressed word; port 1 lanes applied first so port 0 wins overlaps.
  always_comb begin
    rd0_old = mem[bus.adr0];
    rd1_old = mem[bus.adr1];
    rd0_new = rd0_old;
    rd1_new = rd1_old;
    for (int unsigned k = 0; k < lanes; k++) begin
      if (wr1[k])
        rd1_new[k*lane_width +: lane_width] = bus.din1[k*lane_width +: lane_width];
      if (wr1[k] && (bus.adr1 == bus.adr0))
        rd0_new[k*lane_width +: lane_width] = bus.din1[k*lane_width +: lane_width];
      if (wr0[k])
        rd0_new[k*lane_width +: lane_width] = bus.din0[k*lane_width +: lane_width];
      if (wr0[k] && (bus.adr0 == bus.adr1))
        rd1_new[k*lane_width +: lane_width] = bus.din0[k*lane_width +: lane_width];
    end
  end

  always_comb begin
    dout0_d     = '0;
    dout1_d     = '0;
    collision_d = 1'b0;
    if (!busy) begin
      dout0_d     = (rdw_mode == 1) ? rd0_new : rd0_old;
      dout1_d     = (rdw_mode == 1) ? rd1_new : rd1_old;
      collision_d = (bus.adr0 == bus.adr1) && (bus.we0 || bus.we1);
    end
  end

  // Storage array, deliberately not reset; port 0 lane writes come last so they win.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[cnt_q] <= '0;
    for (int unsigned k = 0; k < lanes; k++) begin
      if (wr1[k])
        mem[bus.adr1][k*lane_width +: lane_width] <= bus.din1[k*lane_width +: lane_width];
      if (wr0[k])
        mem[bus.adr0][k*lane_width +: lane_width] <= bus.din0[k*lane_width +: lane_width];
    end
  end

  assign bus.busy      = busy;
  assign bus.collision = collision_q;
  assign bus.dout0     = dout0_q;
  assign bus.dout1     = dout1_q;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: read-first and write-first instances share stimulus and
// are compared against an array-based reference model.
module tb_dpram_be_clr;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = 9;
  localparam int unsigned LN    = 4;
  localparam int unsigned DW    = LN * LW;
  localparam int          DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dpram_be_clr_if #(.adr_width(AW), .lane_width(LW), .lanes(LN)) bus0 ();
  dpram_be_clr_if #(.adr_width(AW), .lane_width(LW), .lanes(LN)) bus1 ();

  assign bus1.clear = bus0.clear;
  assign bus1.adr0  = bus0.adr0;
  assign bus1.we0   = bus0.we0;
  assign bus1.sel0  = bus0.sel0;
  assign bus1.din0  = bus0.din0;
  assign bus1.adr1  = bus0.adr1;
  assign bus1.we1   = bus0.we1;
  assign bus1.sel1  = bus0.sel1;
  assign bus1.din1  = bus0.din1;

  dpram_be_clr #(.adr_width(AW), .lane_width(LW), .lanes(LN), .rdw_mode(0)) dut_rf (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  dpram_be_clr #(.adr_width(AW), .lane_width(LW), .lanes(LN), .rdw_mode(1)) dut_wf (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  int            m_idx;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus0.clear = 1'b0;
    bus0.we0 = 1'b0; bus0.sel0 = '0; bus0.din0 = '0;
    bus0.we1 = 1'b0; bus0.sel1 = '0; bus0.din1 = '0;
  endtask

  task automatic model_reset();
    m_left = DEPTH;
    m_idx  = 0;
  endtask

  // One clock: predict from the model, advance one edge, compare both instances.
  task automatic step();
    logic [DW-1:0] old0, old1, new0, new1;
    logic          ecoll;
    old0 = '0; old1 = '0; new0 = '0; new1 = '0; ecoll = 1'b0;
    if (m_left > 0) begin
      m_mem[m_idx] = '0;
      m_idx++;
      m_left--;
    end else begin
      old0 = m_mem[bus0.adr0];
      old1 = m_mem[bus0.adr1];
      for (int k = 0; k < int'(LN); k++)
        if (bus0.we1 && bus0.sel1[k]) m_mem[bus0.adr1][k*LW +: LW] = bus0.din1[k*LW +: LW];
      for (int k = 0; k < int'(LN); k++)
        if (bus0.we0 && bus0.sel0[k]) m_mem[bus0.adr0][k*LW +: LW] = bus0.din0[k*LW +: LW];
      new0  = m_mem[bus0.adr0];
      new1  = m_mem[bus0.adr1];
      ecoll = (bus0.adr0 == bus0.adr1) && (bus0.we0 || bus0.we1);
      if (bus0.clear) model_reset();
    end
    @(posedge clk);
    #1;
    check("rf_dout0", bus0.dout0, old0);
    check("rf_dout1", bus0.dout1, old1);
    check("wf_dout0", bus1.dout0, new0);
    check("wf_dout1", bus1.dout1, new1);
    check("rf_coll", DW'(bus0.collision), DW'(ecoll));
    check("wf_coll", DW'(bus1.collision), DW'(ecoll));
    check("rf_busy", DW'(bus0.busy), DW'(m_left > 0));
    check("wf_busy", DW'(bus1.busy), DW'(m_left > 0));
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    while (bus0.busy && n < 40) begin
      step();
      n++;
    end
    check(tag, DW'(n), DW'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    set_idle();
    bus0.adr0 = '0;
    bus0.adr1 = '0;
    reset_n = 1'b0;
    #2;
    check("rst_dout0", bus0.dout0, '0);
    check("rst_dout1", bus1.dout1, '0);
    check("rst_coll", DW'(bus0.collision), '0);
    check("rst_busy", DW'(bus1.busy), DW'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

    // Writes during the sweep must be dropped, and a same-address pair must not flag.
    bus0.we0 = 1'b1; bus0.adr0 = 4'd2; bus0.sel0 = 4'hF; bus0.din0 = 36'hFFF;
    bus0.adr1 = 4'd2;
    wait_sweep("sweep_len");
    set_idle();

    for (int a = 0; a < DEPTH; a++) begin
      bus0.adr0 = AW'(a);
      bus0.adr1 = AW'(DEPTH - 1 - a);
      step();
    end
    bus0.adr0 = 4'd2; bus0.adr1 = 4'd15;
    step();
    check("adr2_zero", bus0.dout0, '0);
    check("adr15_zero", bus1.dout1, '0);

    // Partial lane write then read from the other port.
    bus0.we0 = 1'b1; bus0.adr0 = 4'd3; bus0.sel0 = 4'b0101; bus0.din0 = 36'h1_2345_6789;
    bus0.adr1 = 4'd9;
    step();
    set_idle();
    bus0.adr1 = 4'd3; bus0.adr0 = 4'd0;
    step();
    check("lane_merge", bus0.dout1, 36'h0_0344_0189);

    // Read-during-write across ports.
    bus0.we0 = 1'b1; bus0.adr0 = 4'd5; bus0.sel0 = 4'hF; bus0.din0 = 36'hA;
    bus0.adr1 = 4'd6;
    step();
    set_idle();
    bus0.adr0 = 4'd5;
    bus0.we1 = 1'b1; bus0.adr1 = 4'd5; bus0.sel1 = 4'hF; bus0.din1 = 36'hB;
    step();
    check("rdw_rf", bus0.dout0, 36'hA);
    check("rdw_wf", bus1.dout0, 36'hB);
    set_idle();
    step();

    // Dual write, overlapping lane 1 resolved to port 0.
    bus0.we0 = 1'b1; bus0.adr0 = 4'd7; bus0.sel0 = 4'b0011; bus0.din0 = 36'h0_0000_0111;
    bus0.we1 = 1'b1; bus0.adr1 = 4'd7; bus0.sel1 = 4'b0110; bus0.din1 = 36'h0_0022_2200;
    step();
    check("dual_wf", bus1.dout1, 36'h0_0020_0111);
    set_idle();
    step();
    check("dual_read", bus0.dout0, 36'h0_0020_0111);

    // Same-port write with sel=0 is a no-op but still a collision.
    bus0.we0 = 1'b1; bus0.adr0 = 4'd7; bus0.sel0 = '0; bus0.din0 = 36'hF_FFFF_FFFF;
    bus0.adr1 = 4'd7;
    step();
    set_idle();
    step();

    // Requested clear sweep, then reset partway through it.
    bus0.clear = 1'b1;
    step();
    bus0.clear = 1'b0;
    bus0.we1 = 1'b1; bus0.adr1 = 4'd2; bus0.sel1 = 4'hF; bus0.din1 = 36'hFFF;
    for (int i = 0; i < 8; i++) step();
    reset_n = 1'b0;
    #2;
    check("mid_rst_dout0", bus1.dout0, '0);
    check("mid_rst_coll", DW'(bus1.collision), '0);
    check("mid_rst_busy", DW'(bus0.busy), DW'(1));
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    wait_sweep("resweep_len");
    set_idle();
    bus0.adr0 = 4'd2; bus0.adr1 = 4'd7;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus0.clear = ($urandom_range(0, 63) == 0);
      bus0.adr0  = AW'($urandom_range(0, DEPTH - 1));
      bus0.adr1  = $urandom_range(0, 1) ? bus0.adr0 : AW'($urandom_range(0, DEPTH - 1));
      bus0.we0   = $urandom_range(0, 1) == 1;
      bus0.we1   = $urandom_range(0, 1) == 1;
      bus0.sel0  = LN'($urandom_range(0, 15));
      bus0.sel1  = LN'($urandom_range(0, 15));
      bus0.din0  = DW'({$urandom(), $urandom()});
      bus0.din1  = DW'({$urandom(), $urandom()});
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
